// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
// Shared constants and types for the cache-line to word-bus burst controller.
//   WORD_W      : width of one memory-bus beat
//   BEATS       : beats per cache line
//   LINE_W      : cache line width (WORD_W * BEATS)
//   LINE_ADDR_W : cache line address width
//   BEAT_W      : width of the beat index inside a line
//   BUS_ADDR_W  : word address width on the memory bus
package mem_bus_pkg;

  localparam int WORD_W      = 32;
  localparam int BEATS       = 8;
  localparam int LINE_W      = WORD_W * BEATS;
  localparam int LINE_ADDR_W = 27;
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int BUS_ADDR_W  = LINE_ADDR_W + BEAT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2,
    DONE   = 2'd3
  } burst_state_t;

endpackage

// File: rtl/mem_burst_ctrl_line_buf.sv
// line_buf
// One cache line of storage with word-granular access.
//   clk, rst   : clock and asynchronous active-high reset (clears the line)
//   par_load   : load the whole line from par_data (wins over beat_load)
//   par_data   : parallel line input
//   beat_load  : store beat_data into the slice selected by beat_sel
//   beat_sel   : beat index for both the store and the read-out mux
//   beat_data  : word to store
//   line       : current line contents
//   beat_out   : slice of the line selected by beat_sel
module line_buf
  import mem_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              par_load,
  input  logic [LINE_W-1:0] par_data,
  input  logic              beat_load,
  input  logic [BEAT_W-1:0] beat_sel,
  input  logic [WORD_W-1:0] beat_data,
  output logic [LINE_W-1:0] line,
  output logic [WORD_W-1:0] beat_out
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (par_load) begin
      line_q <= par_data;
    end else if (beat_load) begin
      line_q[int'(beat_sel) * WORD_W +: WORD_W] <= beat_data;
    end
  end

  assign line     = line_q;
  assign beat_out = line_q[int'(beat_sel) * WORD_W +: WORD_W];

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Turns 256-bit cache line reads/write-backs into 8-beat word bursts on a
// req/ack memory bus, and returns one single-cycle mem_ready per line.
//   clk, rst   : clock, asynchronous active-high reset
//   mem_read   : line read request (level, held until mem_ready)
//   mem_write  : line write-back request (level, held until mem_ready)
//   mem_addr   : line address
//   mem_wdata  : write-back line
//   mem_rdata  : fetched line (holds until the next read burst)
//   mem_ready  : one-cycle completion pulse
//   bus_req    : beat request to memory
//   bus_we     : 1 = write beat, 0 = read beat
//   bus_addr   : word address {line address, beat}
//   bus_wdata  : write beat data
//   bus_rdata  : read beat data, valid with bus_ack
//   bus_ack    : beat completes when high with bus_req at a rising edge
module mem_burst_ctrl
  import mem_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]      mem_wdata,
  output logic [LINE_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [BUS_ADDR_W-1:0]  bus_addr,
  output logic [WORD_W-1:0]      bus_wdata,
  input  logic [WORD_W-1:0]      bus_rdata,
  input  logic                   bus_ack
);

  burst_state_t           state, state_next;
  logic [BEAT_W-1:0]      beat_q;
  logic [LINE_ADDR_W-1:0] addr_q;

  logic in_burst;
  logic beat_done;
  logic last_beat;
  logic start_wr;
  logic start_rd;

  logic [WORD_W-1:0] wr_beat;
  logic [LINE_W-1:0] wr_line_unused;
  logic [WORD_W-1:0] rd_beat_unused;

  assign in_burst  = (state == WBURST) || (state == RBURST);
  assign beat_done = in_burst && bus_ack;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  // A simultaneous read and write resolves to the write; the cache reissues the read.
  assign start_wr  = (state == IDLE) && mem_write;
  assign start_rd  = (state == IDLE) && !mem_write && mem_read;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_wr) begin
          state_next = WBURST;
        end else if (start_rd) begin
          state_next = RBURST;
        end
      end
      WBURST, RBURST: begin
        if (beat_done && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic; the bus is parked at zero outside a burst
  always_comb begin
    mem_ready = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (state)
      WBURST: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {addr_q, beat_q};
        bus_wdata = wr_beat;
      end
      RBURST: begin
        bus_req  = 1'b1;
        bus_addr = {addr_q, beat_q};
      end
      DONE: begin
        mem_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Line address latch and beat counter. The counter parks on the last
  // beat rather than wrapping, and restarts only with a new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      beat_q <= '0;
    end else if (start_wr || start_rd) begin
      addr_q <= mem_addr;
      beat_q <= '0;
    end else if (beat_done && !last_beat) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Write-back line, captured whole when the write starts
  line_buf u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .par_load  (start_wr),
    .par_data  (mem_wdata),
    .beat_load (1'b0),
    .beat_sel  (beat_q),
    .beat_data ('0),
    .line      (wr_line_unused),
    .beat_out  (wr_beat)
  );

  // Read line, assembled beat by beat; kept separate so a write-back
  // never disturbs mem_rdata
  line_buf u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .par_load  (1'b0),
    .par_data  ('0),
    .beat_load (state == RBURST && bus_ack),
    .beat_sel  (beat_q),
    .beat_data (bus_rdata),
    .line      (mem_rdata),
    .beat_out  (rd_beat_unused)
  );

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Memory-side neighbour of the direct-mapped data cache. It consumes the cache's 256-bit line requests (mem_read/mem_write/mem_addr/mem_wdata) and returns mem_rdata/mem_ready.
- Each line transfer becomes an 8-beat burst of 32-bit words on a req/ack word bus to main memory.
- Captures the write line and assembles the read line in a local buffer, so the cache sees a single-cycle mem_ready pulse per completed line.

Parameters:
- WORD_W, 32, width of one bus beat
- BEATS, 8, beats per cache line (line = WORD_W*BEATS = 256 bits)
- LINE_ADDR_W, 27, cache line address width
- BUS_ADDR_W, 30, word address width on the memory bus (LINE_ADDR_W + log2(BEATS))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  cache line read request; level, held until mem_ready
- mem_write  in  1  cache line write-back request; level, held until mem_ready
- mem_addr  in  27  line address
- mem_wdata  in  256  write-back line
- mem_rdata  out  256  fetched line
- mem_ready  out  1  one-cycle completion pulse
- bus_req  out  1  beat request to memory
- bus_we  out  1  1=write beat, 0=read beat
- bus_addr  out  30  word address {line_addr, beat[2:0]}
- bus_wdata  out  32  write beat data
- bus_rdata  in  32  read beat data, valid with bus_ack
- bus_ack  in  1  beat accepted/completed when sampled high with bus_req at a rising edge

Behaviour:
- Reset (async, rst=1): state IDLE; mem_ready=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_rdata=0, beat counter=0. Reset mid-burst abandons the burst; no mem_ready is issued for it.
- States: IDLE, WBURST, RBURST, DONE.
- IDLE:
  - mem_write=1: latch mem_addr and mem_wdata, beat=0, go to WBURST.
  - else mem_read=1: latch mem_addr, beat=0, go to RBURST.
  - Both high: write wins (the read is reissued by the cache afterwards).
- WBURST/RBURST:
  - bus_req=1. bus_we=1 in WBURST, 0 in RBURST.
  - bus_addr={latched_addr, beat}.
  - bus_wdata = latched line bits [32*beat+31 : 32*beat].
  - Outputs hold stable until bus_ack.
  - On req&ack: a read stores bus_rdata into line buffer bits [32*beat+31 : 32*beat]; beat increments.
  - On the ack of beat BEATS-1, go to DONE.
- DONE: mem_ready=1 for exactly one cycle, bus_req=0, then IDLE.
- mem_rdata:
  - Driven from the read line buffer; holds its value until the next read burst overwrites it beat by beat.
  - Valid when mem_ready=1 after a read. After a write burst it is don't-care for the cache, but must not change.
- Request inputs are sampled only in IDLE. Changes to mem_addr/mem_wdata during a burst are ignored.
- The cache drops its request at the edge where it sees mem_ready. A request seen in IDLE the cycle after DONE is a new transaction; this gives back-to-back write-back then allocate.
- Latency: request first high in cycle c, ack every cycle → mem_ready high in cycle c+9. Each ack wait cycle adds one.
- bus_ack while bus_req=0 is ignored.
- Beat counter is 3 bits, wraps only via reset/new transaction; never exceeds BEATS-1.

Decomposition:
- Shared package mem_bus_pkg holds:
  - constants WORD_W, BEATS, LINE_W, LINE_ADDR_W, BUS_ADDR_W
  - state enum {IDLE, WBURST, RBURST, DONE}
- One sub-module, line_buf:
  - 256-bit register with a write-beat mux (select 32-bit slice by beat)
  - a read-beat load (store 32-bit slice by beat)
  - a parallel line load
- The FSM and beat counter stay in mem_burst_ctrl.

Test Plan:
- Reset mid-RBURST at beat 3 → bus_req=0, mem_ready never pulses, state IDLE; next read completes normally.
- Read, addr=27'h000_0012, ack every cycle, memory word k=32'hA000_0000+k → bus_addr 30'h90..97 in order; mem_ready in cycle c+9; mem_rdata=={A0000007,…,A0000000}.
- Write, addr=27'h1, mem_wdata=256'h…07_06_05_04_03_02_01_00 (word k=k) → 8 write beats with bus_addr 8..15, bus_wdata=0..7, single mem_ready pulse; mem_rdata unchanged.
- Random 0–3 cycle ack stalls on a read → bus_addr/bus_we stable while unacked; line assembled correctly; mem_ready once.
- Write-back then allocate: mem_write then mem_read on the cycle after mem_ready → two bursts back-to-back, no lost or duplicated request, each mem_ready exactly one cycle.
- mem_read and mem_write both high in IDLE → write burst first; bus_ack asserted while idle causes no state change.
